restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand and result width in bits, with WIDTH >= 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division; sampled on the rising edge.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned dividend, captured when start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned divisor, captured when start is accepted.
REQ-007 SHALL have port quotient, output, WIDTH bits: registered unsigned quotient.
REQ-008 SHALL have port remainder, output, WIDTH bits: registered unsigned remainder.
REQ-009 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when new results are valid.
REQ-011 SHALL have port div_by_zero, output, 1 bit: registered flag for a zero divisor in the last completed operation.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance it captures dividend and divisor, clears the partial remainder and step counter, and enters CALC; busy is high from the next cycle.
REQ-014 SHALL ignore start while in CALC: no recapture, no restart, and no effect on the current operation.
REQ-015 SHALL perform one restoring step per clock edge in CALC, as follows:
- shift the (WIDTH+1)-bit partial remainder left by one;
- shift in the current dividend MSB;
- form trial = partial remainder + ~{0,divisor} + 1, a two's-complement subtract using inverted divisor with carry-in 1;
- if trial MSB = 0, keep trial and shift in a quotient bit of 1;
- otherwise restore the partial remainder and shift in a quotient bit of 0.
REQ-016 SHALL complete exactly WIDTH steps. The step-WIDTH edge loads quotient and remainder (low WIDTH bits), clears div_by_zero and moves to DONE.
REQ-017 SHALL drive done=1 and busy=0 for exactly one cycle in DONE. Latency from the accepting edge to done high is WIDTH cycles.
REQ-018 SHALL, when the captured divisor is 0, skip CALC. The accepting edge goes directly to DONE and sets quotient = all ones, remainder = dividend and div_by_zero = 1. done pulses on the following cycle and busy stays 0.
REQ-019 SHALL move from DONE to IDLE when start is low, or directly to CALC or DONE (per REQ-018) when start is high.
REQ-020 SHALL hold quotient, remainder and div_by_zero stable from the completion edge until the next completion edge, including throughout CALC.
REQ-021 SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor, including dividend < divisor (quotient 0) and divisor 1 (quotient = dividend).
REQ-022 SHALL never drive busy and done high in the same cycle.

Reset
REQ-023 SHALL, with rst high at an edge, set the state to IDLE and clear to 0: quotient, remainder, busy, done, div_by_zero, the step counter and the internal registers.
REQ-024 SHALL give rst priority over start and abort any in-progress operation, with no done pulse for the aborted operation.
REQ-025 SHALL accept start on the first edge after rst deasserts.

Verification
REQ-026 SHALL cover: WIDTH=4, start with dividend=13 and divisor=3 -> busy for 4 cycles, then done pulse with quotient=4, remainder=1, div_by_zero=0.
REQ-027 SHALL cover: dividend=15 and divisor=1 -> quotient=15 and remainder=0; then dividend=2 and divisor=9 -> quotient=0 and remainder=2.
REQ-028 SHALL cover: dividend=7 and divisor=0 -> done one cycle after acceptance, busy never high, quotient=15, remainder=7, div_by_zero=1. A following 8/2 clears div_by_zero and gives quotient=4, remainder=0.
REQ-029 SHALL cover: start 9/4 pulsed, then start 15/1 on the second busy cycle -> result is quotient=2, remainder=1, with a single done pulse.
REQ-030 SHALL cover: rst asserted on the second CALC cycle -> all outputs 0 and IDLE next cycle, no done pulse; a new start 6/6 gives quotient=1, remainder=0.
REQ-031 SHALL cover: start held high continuously with 10/3 -> back-to-back operations, each with done pulsing for one cycle, quotient=3, remainder=1, and busy low only in the DONE cycles.

Source files
------------

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH steps per operation.
// Latency: done pulses WIDTH cycles after the accepting edge (one cycle for a zero divisor).
// Backpressure: start is only accepted in IDLE or DONE; it is ignored while busy.
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Step counter runs 0..WIDTH-1; WIDTH >= 2 keeps CW at least 1 bit.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_work;   // dividend bits shift out of the MSB, quotient bits shift into the LSB
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_prem;   // partial remainder, one bit wider than the operands

    logic             w_accept;
    logic             w_zero;
    logic             w_last;
    logic             w_qbit;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_prem_nxt;
    logic [WIDTH-1:0] w_work_nxt;

    assign w_zero = (divisor == '0);
    assign w_last = (r_cnt == LAST_STEP);

    // One restoring step: shift in the next dividend bit, try subtracting the divisor
    // (inverted divisor plus carry-in), keep the difference only if it did not go negative.
    assign w_shift    = (r_prem << 1) | {{WIDTH{1'b0}}, r_work[WIDTH-1]};
    assign w_trial    = w_shift + ~{1'b0, r_dvs} + (WIDTH+1)'(1);
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_prem_nxt = w_qbit ? w_trial : w_shift;
    assign w_work_nxt = {r_work[WIDTH-2:0], w_qbit};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, start acceptance and status outputs.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? S_DONE : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result registers; results only change at a completion edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work      <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_work <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
            r_cnt  <= '0;
            if (w_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (r_state == S_CALC) begin
            r_work <= w_work_nxt;
            r_prem <= w_prem_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                quotient    <= w_work_nxt;
                remainder   <= w_prem_nxt[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed corner cases plus random operands.
// Results are predicted with plain integer division; timing from the operation rules.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    // Last completed result as predicted by the bench; outputs must hold these while busy.
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;
    logic         prev_z;

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic scramble();
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Present start for one edge; returns at the first falling edge after acceptance.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    // Observes from cycle k0 after the accepting edge until the done pulse.
    // Nonzero divisor: busy in cycles 1..W, done in cycle W+1. Zero divisor: done in cycle 1.
    task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int k0, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           busy_n;
        bit           seen;
        if (b == '0) begin
            eq = '1;
            er = a;
            ez = 1'b1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = 1'b0;
        end
        busy_n = k0 - 1;
        seen   = 1'b0;
        for (int k = k0; k <= W + 3 && !seen; k++) begin
            if (k > k0) @(negedge clk);
            check({tag, " busy_and_done"}, {31'd0, busy & done}, 32'd0);
            if (done) begin
                seen = 1'b1;
                check({tag, " done_cycle"}, k, (b == '0) ? 1 : W + 1);
                check({tag, " busy_cycles"}, busy_n, (b == '0) ? 0 : W);
                check({tag, " quotient"}, quotient, eq);
                check({tag, " remainder"}, remainder, er);
                check({tag, " div_by_zero"}, div_by_zero, ez);
            end else begin
                if (busy) busy_n++;
                check({tag, " hold_q"}, quotient, prev_q);
                check({tag, " hold_r"}, remainder, prev_r);
                check({tag, " hold_z"}, div_by_zero, prev_z);
            end
        end
        if (!seen) check({tag, " done_timeout"}, 32'd0, 32'd1);
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    // With start low the DUT must go quiet: no further done pulse, not busy.
    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({tag, " idle_done"}, done, 1'b0);
            check({tag, " idle_busy"}, busy, 1'b0);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        launch(a, b);
        wait_result(a, b, 1, tag);
        check_idle(tag);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        prev_z   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_by_zero", div_by_zero, 0);

        // Start presented on the very first edge after reset release.
        rst      = 1'b0;
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        scramble();
        wait_result(4'd13, 4'd3, 1, "13/3");
        check_idle("13/3");

        run_op(4'd15, 4'd1, "15/1");
        run_op(4'd2, 4'd9, "2/9");
        run_op(4'd7, 4'd0, "7/0");
        run_op(4'd8, 4'd2, "8/2");

        // A second start on the second busy cycle must be ignored.
        launch(4'd9, 4'd4);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        wait_result(4'd9, 4'd4, 3, "9/4 ignore");
        check_idle("9/4 ignore");

        // Reset during the second CALC cycle aborts with no done pulse.
        launch(4'd11, 4'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort div_by_zero", div_by_zero, 0);
        rst    = 1'b0;
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        check_idle("abort");
        run_op(4'd6, 4'd6, "6/6");

        // Start held high: back-to-back operations, re-accepted from DONE.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd10;
        divisor  = 4'd3;
        @(negedge clk);
        wait_result(4'd10, 4'd3, 1, "10/3 b2b0");
        for (int n = 1; n < 3; n++) begin
            @(negedge clk);
            wait_result(4'd10, 4'd3, 1, "10/3 b2b");
        end
        start = 1'b0;
        check_idle("10/3 b2b");

        // Random operands; a zero divisor comes up naturally now and then.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 8 == 0) rb = '0;
            launch(ra, rb);
            wait_result(ra, rb, 1, "random");
            if ($urandom_range(0, 1) == 1) check_idle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
